// File: rtl/bcx_sched_pkg.sv
// Shared types and defaults for the block-hash round scheduler.
// The state enum is also exported on the top's debug port.
package bcx_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_state_t;

  localparam int unsigned DEF_NUM_CORES     = 10;
  localparam int unsigned DEF_BROADCAST_CNT = 100;
  localparam int unsigned DEF_MAX_INFLIGHT  = 4;
  localparam int unsigned BASE_W            = 32;

endpackage

// File: rtl/inflight_credit_ctr.sv
// Up/down counter of issued-but-unretired rounds.
// It saturates at both ends, and flags a decrement that arrives while the counter is empty.
module inflight_credit_ctr #(
  parameter  int unsigned MAX_COUNT = 4,
  localparam int unsigned CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          underflow
);

  localparam logic [CW-1:0] MAX_L = CW'(MAX_COUNT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Simultaneous inc and dec cancel; a decrement on empty is dropped and reported.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && (count_q != MAX_L)) begin
      count_d = count_q + CW'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign full      = (count_q == MAX_L);
  assign empty     = (count_q == '0);
  assign underflow = dec && !inc && (count_q == '0);

endmodule

// File: rtl/nonce_round_scheduler.sv
// Runs one block-hash job. It issues BROADCAST_CNT rounds of NUM_CORES nonces each, and limits in-flight rounds with credits.
// Issuing stops after a hit or an abort. The job drains all in-flight rounds, then pulses done.
module nonce_round_scheduler
  import bcx_sched_pkg::*;
#(
  parameter int unsigned NUM_CORES     = DEF_NUM_CORES,
  parameter int unsigned BROADCAST_CNT = DEF_BROADCAST_CNT,
  parameter int unsigned MAX_INFLIGHT  = DEF_MAX_INFLIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              issue_ready_i,
  output logic              issue_valid_o,
  output logic              issue_newblock_o,
  output logic [BASE_W-1:0] issue_base_o,
  input  logic              retire_i,
  input  logic              retire_success_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic              protocol_err_o,
  output sched_state_t      dbg_state
);

  localparam int unsigned     IW     = $clog2(BROADCAST_CNT + 1);
  localparam int unsigned     FW     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0]   CNT_L  = IW'(BROADCAST_CNT);
  localparam logic [BASE_W-1:0] STRIDE = BASE_W'(NUM_CORES);

  sched_state_t      state_q, state_d;
  logic [IW-1:0]     issued_q, issued_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic              hit_q, hit_d;
  logic              perr_q, perr_d;

  logic [FW-1:0]     inflight;
  logic              cr_full;
  logic              cr_empty;
  logic              cr_underflow;

  logic              job_start;
  logic              offer;
  logic              fire;
  logic              retire_ok;

  // Handshake: a round transfers on a cycle where issue_valid_o and issue_ready_i are both high.
  // Valid, base and newblock come only from registered state. They do not depend on ready,
  // so they hold steady while the datapath stalls.
  assign job_start = (state_q == S_IDLE) && start_i;
  assign offer     = (state_q == S_ISSUE) && !cr_full && (issued_q < CNT_L) && !hit_q;
  assign fire      = offer && issue_ready_i;
  assign retire_ok = retire_i && !cr_underflow;

  inflight_credit_ctr #(
    .MAX_COUNT (MAX_INFLIGHT)
  ) u_credit (
    .clk       (clk),
    .rst       (rst),
    .clr       (job_start),
    .inc       (fire),
    .dec       (retire_i),
    .count     (inflight),
    .full      (cr_full),
    .empty     (cr_empty),
    .underflow (cr_underflow)
  );

  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    base_d   = base_q;
    hit_d    = hit_q;
    perr_d   = perr_q || cr_underflow;

    if (retire_ok && retire_success_i) begin
      hit_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_ISSUE;
          issued_d = '0;
          base_d   = '0;
          hit_d    = 1'b0;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          issued_d = issued_q + IW'(1);
          base_d   = base_q + STRIDE;
        end
        // A round that fires on the exit cycle still counts.
        if ((issued_d == CNT_L) || hit_d || abort_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cr_empty || ((inflight == FW'(1)) && retire_ok)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      issued_q <= '0;
      base_q   <= '0;
      hit_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      base_q   <= base_d;
      hit_q    <= hit_d;
      perr_q   <= perr_d;
    end
  end

  assign issue_valid_o    = offer;
  assign issue_newblock_o = offer && (issued_q == '0);
  assign issue_base_o     = base_q;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign found_o          = (state_q == S_DONE) && hit_q;
  assign protocol_err_o   = perr_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_nonce_round_scheduler.sv
// Bench for nonce_round_scheduler. It runs directed job scenarios and randomized jobs.
// Each cycle is compared against a job-level reference model.
module tb_nonce_round_scheduler;
  import bcx_sched_pkg::*;

  localparam int NC   = 10;
  localparam int CNT  = 8;
  localparam int MAXF = 4;

  logic        clk;
  logic        rst;
  logic        start_i, abort_i, issue_ready_i, retire_i, retire_success_i;
  logic        issue_valid_o, issue_newblock_o;
  logic [31:0] issue_base_o;
  logic        busy_o, done_o, found_o, protocol_err_o;
  sched_state_t dbg_state;

  nonce_round_scheduler #(
    .NUM_CORES     (NC),
    .BROADCAST_CNT (CNT),
    .MAX_INFLIGHT  (MAXF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .abort_i          (abort_i),
    .issue_ready_i    (issue_ready_i),
    .issue_valid_o    (issue_valid_o),
    .issue_newblock_o (issue_newblock_o),
    .issue_base_o     (issue_base_o),
    .retire_i         (retire_i),
    .retire_success_i (retire_success_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .found_o          (found_o),
    .protocol_err_o   (protocol_err_o),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking and scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  int fire_cnt;
  int done_cnt;
  logic last_found;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model (job-level bookkeeping) ----------------
  // phase: 0 idle, 1 issuing, 2 draining, 3 done
  int m_phase, m_fired, m_out;
  bit m_hit, m_perr;

  function automatic bit m_can_issue();
    return (m_phase == 1) && (m_out < MAXF) && (m_fired < CNT) && !m_hit;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_fired = 0; m_out = 0; m_hit = 0; m_perr = 0;
  endtask

  task automatic check_outputs();
    bit can;
    can = m_can_issue();
    check_eq("valid",    issue_valid_o,    can);
    check_eq("newblock", issue_newblock_o, can && (m_fired == 0));
    check_eq("base",     issue_base_o,     m_fired * NC);
    check_eq("busy",     busy_o,           m_phase != 0);
    check_eq("done",     done_o,           m_phase == 3);
    check_eq("found",    found_o,          (m_phase == 3) && m_hit);
    check_eq("perr",     protocol_err_o,   m_perr);
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs at the current negedge and advances the model.
  // It then checks the outputs at the following negedge.
  task automatic step(input bit st, input bit ab, input bit rdy, input bit ret, input bit suc);
    bit fire, ret_ok;
    start_i = st; abort_i = ab; issue_ready_i = rdy;
    retire_i = ret; retire_success_i = suc;
    if (issue_valid_o && rdy) begin
      fire_cnt++;
      if (exp_q.size() == 0) check_eq("unexpected_fire_base", issue_base_o, 32'hFFFF_FFFF);
      else check_eq("fire_base", issue_base_o, exp_q.pop_front());
    end
    fire   = m_can_issue() && rdy;
    ret_ok = ret && ((m_out > 0) || fire);
    if (ret && (m_out == 0) && !fire) m_perr = 1;
    case (m_phase)
      0: if (st) begin m_phase = 1; m_fired = 0; m_out = 0; m_hit = 0; end
      1: begin
        if (fire) begin m_fired++; m_out++; end
        if (ret_ok) begin m_out--; if (suc) m_hit = 1; end
        if ((m_fired == CNT) || m_hit || ab) m_phase = 2;
      end
      2: begin
        if (ret_ok) begin m_out--; if (suc) m_hit = 1; end
        if (m_out == 0) m_phase = 3;
      end
      default: m_phase = 0;
    endcase
    @(negedge clk);
    check_outputs();
    if (done_o) begin done_cnt++; last_found = found_o; end
  endtask

  task automatic job_prep();
    exp_q.delete();
    for (int k = 0; k < CNT; k++) exp_q.push_back(32'(k * NC));
    fire_cnt = 0; done_cnt = 0; last_found = 0;
  endtask

  // ready held high; each round retires three cycles after it fires
  task automatic run_pipe(input int succ_at);
    int ret_t[$];
    int nret, t;
    bit r, s;
    nret = 0; t = 0;
    step(1, 0, 1, 0, 0);
    while ((m_phase != 0) && (t < 200)) begin
      r = (ret_t.size() > 0) && (ret_t[0] == t);
      if (r) begin void'(ret_t.pop_front()); nret++; end
      s = r && (nret == succ_at);
      if (m_can_issue()) ret_t.push_back(t + 3);
      step(0, 0, 1, r, s);
      t++;
    end
    check_eq("pipe_job_idle", busy_o, 0);
  endtask

  // ready low; retire whatever is in flight until the job ends
  task automatic finish_job();
    int t;
    t = 0;
    while ((m_phase != 0) && (t < 100)) begin
      step(0, 0, 0, m_out > 0, 0);
      t++;
    end
    check_eq("finish_idle", busy_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    start_i = 0; abort_i = 0; issue_ready_i = 0; retire_i = 0; retire_success_i = 0;
    model_reset();
    #3;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // full job, no hit
    job_prep();
    run_pipe(0);
    check_eq("t1_fires", fire_cnt, 8);
    check_eq("t1_all_bases", exp_q.size(), 0);
    check_eq("t1_done_pulses", done_cnt, 1);
    check_eq("t1_found", last_found, 0);

    // hit on the third retire (round at base 20)
    job_prep();
    run_pipe(3);
    check_eq("t2_fires", fire_cnt, 6);
    check_eq("t2_done_pulses", done_cnt, 1);
    check_eq("t2_found", last_found, 1);

    // credit limit: no retires; a stray start while busy is ignored
    job_prep();
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(i == 6, 0, 1, 0, 0);
    check_eq("t3_fires_at_credit", fire_cnt, MAXF);
    check_eq("t3_busy", busy_o, 1);
    step(0, 1, 1, 0, 0);
    finish_job();
    check_eq("t3_done_pulses", done_cnt, 1);
    check_eq("t3_found", last_found, 0);

    // ready stall for 5 cycles, then a single fire
    job_prep();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    check_eq("t4_no_fire_stalled", fire_cnt, 0);
    step(0, 0, 1, 0, 0);
    check_eq("t4_one_fire", fire_cnt, 1);
    step(0, 1, 0, 0, 0);
    finish_job();

    // asynchronous reset in the middle of issuing
    job_prep();
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    check_eq("t5_fired_before_rst", fire_cnt, 3);
    start_i = 0; issue_ready_i = 0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    job_prep();
    run_pipe(0);
    check_eq("t5_fresh_fires", fire_cnt, 8);

    // randomized jobs
    for (int j = 0; j < 15; j++) begin
      int t;
      bit rdy, f, r;
      job_prep();
      step(1, $urandom_range(0, 3) == 0, $urandom_range(0, 1), 0, 0);
      t = 0;
      while ((m_phase != 0) && (t < 300)) begin
        rdy = $urandom_range(0, 9) < 7;
        f   = m_can_issue() && rdy;
        r   = ((m_out > 0) || f) && ($urandom_range(0, 9) < 4);
        step($urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, rdy, r,
             r && ($urandom_range(0, 7) == 0));
        t++;
      end
      check_eq("rand_job_idle", busy_o, 0);
      check_eq("rand_done_pulses", done_cnt, 1);
      for (int k = $urandom_range(0, 2); k > 0; k--) step(0, 0, $urandom_range(0, 1), 0, 0);
    end

    // retire with nothing in flight while idle
    step(0, 0, 0, 1, 0);
    check_eq("t6_perr_set", protocol_err_o, 1);
    check_eq("t6_still_idle", busy_o, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    check_eq("t6_perr_sticky", protocol_err_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
